// File: rtl/flap_game_ctrl.sv
// rtl/flap_game_ctrl.sv - game tick, play-state FSM, second-pipe release and BCD score
module flap_game_ctrl #(
  parameter int TICK_DIV    = 50000,
  parameter int PIPE1_DELAY = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       btn_i,
  input  logic       hit_i,
  input  logic       pipe_pass_i,
  input  logic       bird_landed_i,
  output logic       tick_o,
  output logic [1:0] state_o,
  output logic       run_en_o,
  output logic       bird_up_o,
  output logic       bird_en_o,
  output logic       pipe1_en_o,
  output logic [3:0] score_tens_o,
  output logic [3:0] score_ones_o,
  output logic       game_over_o
);

  localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [9:0]    DLY_MAX = 10'(PIPE1_DELAY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          start_m_q, start_s_q;
  logic          btn_m_q, btn_s_q, btn_d_q;
  logic          btn_rise;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [9:0]    dly_q, dly_d;
  logic          pipe1_q, pipe1_d;
  logic          tick_hit;
  logic          score_max;

  assign btn_rise  = btn_s_q & ~btn_d_q;
  assign tick_hit  = tick_q & hit_i;
  assign score_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  // Two-flop synchronizers for the board inputs, plus a delayed copy of btn for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_m_q <= 1'b0;
      start_s_q <= 1'b0;
      btn_m_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      btn_d_q   <= 1'b0;
    end else begin
      start_m_q <= start_i;
      start_s_q <= start_m_q;
      btn_m_q   <= btn_i;
      btn_s_q   <= btn_m_q;
      btn_d_q   <= btn_s_q;
    end
  end

  // Free-running tick divider; tick is raised for the clk in which the count is back at 0
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Tick divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Next state, score and second-pipe delay; a low start overrides every game event
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    dly_d   = dly_q;
    pipe1_d = pipe1_q;

    if (!start_s_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (btn_rise) state_d = S_PLAY;
        S_PLAY:  if (tick_hit) state_d = S_DYING;
        S_DYING: if (tick_q && bird_landed_i) state_d = S_OVER;
        default: state_d = state_q;
      endcase
    end

    if (state_q == S_IDLE) begin
      dly_d   = '0;
      pipe1_d = 1'b0;
      if (start_s_q && btn_rise) begin
        tens_d = '0;
        ones_d = '0;
      end
    end else if (state_q == S_PLAY && start_s_q) begin
      // A pass on the killing tick does not score
      if (pipe_pass_i && !tick_hit && !score_max) begin
        if (ones_q == 4'd9) begin
          ones_d = '0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      if (tick_q && dly_q != DLY_MAX) begin
        dly_d = dly_q + 10'd1;
        if (dly_q + 10'd1 == DLY_MAX) pipe1_d = 1'b1;
      end
    end
  end

  // Game state, score and delay registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tens_q  <= '0;
      ones_q  <= '0;
      dly_q   <= '0;
      pipe1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      dly_q   <= dly_d;
      pipe1_q <= pipe1_d;
    end
  end

  assign tick_o       = tick_q;
  assign state_o      = state_q;
  assign run_en_o     = (state_q == S_PLAY);
  assign bird_en_o    = (state_q == S_PLAY) || (state_q == S_DYING);
  assign bird_up_o    = (state_q == S_PLAY) && btn_s_q;
  assign game_over_o  = (state_q == S_OVER);
  assign pipe1_en_o   = pipe1_q;
  assign score_tens_o = tens_q;
  assign score_ones_o = ones_q;

endmodule

// File: tb/tb_flap_game_ctrl.sv
// tb/tb_flap_game_ctrl.sv - randomized and directed bench for flap_game_ctrl against a behavioural model
module tb_flap_game_ctrl;

  localparam int TDIV = 4;
  localparam int PDLY = 3;
  localparam int IDLE = 0, PLAY = 1, DYING = 2, OVER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, btn = 1'b0, hit = 1'b0, pipe_pass = 1'b0, bird_landed = 1'b0;
  logic       tick_o, run_en_o, bird_up_o, bird_en_o, pipe1_en_o, game_over_o;
  logic [1:0] state_o;
  logic [3:0] score_tens_o, score_ones_o;

  int checks = 0;
  int errors = 0;

  // Reference model: integer score, cycle count since reset, input delay stages
  int m_state, m_score, m_dly, m_cyc;
  bit m_start_m, m_start_s, m_btn_m, m_btn_s, m_btn_d, m_tick, m_pipe1;

  flap_game_ctrl #(.TICK_DIV(TDIV), .PIPE1_DELAY(PDLY)) dut (
    .clk(clk), .rst(rst), .start_i(start), .btn_i(btn), .hit_i(hit),
    .pipe_pass_i(pipe_pass), .bird_landed_i(bird_landed),
    .tick_o(tick_o), .state_o(state_o), .run_en_o(run_en_o), .bird_up_o(bird_up_o),
    .bird_en_o(bird_en_o), .pipe1_en_o(pipe1_en_o), .score_tens_o(score_tens_o),
    .score_ones_o(score_ones_o), .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_score = 0; m_dly = 0; m_cyc = 0; m_pipe1 = 0; m_tick = 0;
    m_start_m = 0; m_start_s = 0; m_btn_m = 0; m_btn_s = 0; m_btn_d = 0;
  endtask

  task automatic check_all();
    chk("tick", {7'd0, tick_o}, {7'd0, m_tick});
    chk("state", {6'd0, state_o}, 8'(m_state));
    chk("run_en", {7'd0, run_en_o}, {7'd0, m_state == PLAY});
    chk("bird_en", {7'd0, bird_en_o}, {7'd0, (m_state == PLAY) || (m_state == DYING)});
    chk("bird_up", {7'd0, bird_up_o}, {7'd0, (m_state == PLAY) && m_btn_s});
    chk("game_over", {7'd0, game_over_o}, {7'd0, m_state == OVER});
    chk("pipe1_en", {7'd0, pipe1_en_o}, {7'd0, m_pipe1});
    chk("score", {score_tens_o, score_ones_o}, bcd(m_score));
  endtask

  task automatic step();
    bit rise, th;
    int ns;
    @(posedge clk);
    rise = m_btn_s && !m_btn_d;
    th   = m_tick && hit;
    ns   = m_state;
    if (!m_start_s) ns = IDLE;
    else if (m_state == IDLE && rise) ns = PLAY;
    else if (m_state == PLAY && th) ns = DYING;
    else if (m_state == DYING && m_tick && bird_landed) ns = OVER;
    if (m_state == IDLE) begin
      m_dly = 0; m_pipe1 = 0;
      if (m_start_s && rise) m_score = 0;
    end else if (m_state == PLAY && m_start_s) begin
      if (pipe_pass && !th && m_score < 99) m_score++;
      if (m_tick && m_dly < PDLY) begin
        m_dly++;
        if (m_dly == PDLY) m_pipe1 = 1;
      end
    end
    m_state = ns;
    m_btn_d = m_btn_s; m_btn_s = m_btn_m; m_btn_m = btn;
    m_start_s = m_start_m; m_start_m = start;
    m_cyc++;
    m_tick = (m_cyc % TDIV == 0);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!m_tick && n < 3 * TDIV) begin
      step();
      n++;
    end
    chk("tick_wait", {7'd0, tick_o}, 8'd1);
  endtask

  task automatic pass_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_pass = 1'b1; step();
      pipe_pass = 1'b0; step();
    end
  endtask

  task automatic enter_play();
    start = 1'b1; steps(3);
    btn = 1'b1; step();
    btn = 1'b0; steps(3);
  endtask

  initial begin
    int tcount;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: ticks every TDIV clks, nothing moves
    for (int i = 1; i <= 12; i++) begin
      btn = 1'($urandom_range(0, 1));
      step();
      if (i % TDIV == 0) chk("tick_period", {7'd0, tick_o}, 8'd1);
    end
    btn = 1'b0;

    // Start a game: PLAY appears on the third edge after the button edge
    start = 1'b1; steps(3);
    btn = 1'b1; step(); step();
    chk("play_lat_early", {6'd0, state_o}, 8'd0);
    step();
    chk("play_lat", {6'd0, state_o}, 8'd1);
    chk("bird_up_held", {7'd0, bird_up_o}, 8'd1);
    step(); btn = 1'b0; steps(3);

    // Second pipe released on the third tick seen in PLAY (counting ticks already consumed)
    tcount = 1;
    for (int i = 0; i < 40 && tcount < PDLY; i++) begin
      if (m_tick) tcount++;
      step();
    end
    chk("pipe1_ticks", 8'(tcount), 8'(PDLY));

    pass_pulses(12);
    chk("score_12", {score_tens_o, score_ones_o}, 8'h12);

    // Death wins over a simultaneous pass
    wait_tick();
    hit = 1'b1; pipe_pass = 1'b1; step();
    hit = 1'b0; pipe_pass = 1'b0;
    chk("dying", {6'd0, state_o}, 8'd2);
    chk("score_kept", {score_tens_o, score_ones_o}, 8'h12);
    wait_tick();
    bird_landed = 1'b1; step();
    bird_landed = 1'b0;
    chk("over", {6'd0, state_o}, 8'd3);
    chk("game_over", {7'd0, game_over_o}, 8'd1);

    // Leaving OVER through start low
    start = 1'b0; steps(2);
    chk("over_hold", {6'd0, state_o}, 8'd3);
    step();
    chk("idle_again", {6'd0, state_o}, 8'd0);
    chk("score_in_idle", {score_tens_o, score_ones_o}, 8'h12);
    enter_play();
    chk("replay_state", {6'd0, state_o}, 8'd1);
    chk("replay_score", {score_tens_o, score_ones_o}, 8'h00);
    chk("replay_pipe1", {7'd0, pipe1_en_o}, 8'd0);

    pass_pulses(105);
    chk("score_sat", {score_tens_o, score_ones_o}, 8'h99);

    // Randomized play against the model
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom_range(0, 59) != 0);
      btn         = ($urandom_range(0, 5) == 0);
      hit         = ($urandom_range(0, 9) == 0);
      pipe_pass   = ($urandom_range(0, 2) == 0);
      bird_landed = ($urandom_range(0, 3) == 0);
      step();
    end
    hit = 1'b0; pipe_pass = 1'b0; bird_landed = 1'b0; btn = 1'b0;

    // Asynchronous reset in the middle of a game
    start = 1'b0; steps(3);
    enter_play();
    pass_pulses(7);
    chk("pre_rst_score", {score_tens_o, score_ones_o}, 8'h07);
    chk("pre_rst_state", {6'd0, state_o}, 8'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_state", {6'd0, state_o}, 8'd0);
    chk("rst_score", {score_tens_o, score_ones_o}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i % TDIV == 0) chk("tick_restart", {7'd0, tick_o}, 8'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
